// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-ported memory between an instruction-fetch
//            requester (IF) and a data requester (DM). DM normally wins, but
//            IF is guaranteed a grant after STARVE_MAX back-to-back DM grants.
//            A stuck memory is detected by a BUSY-cycle timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int ADDR_W     = 10,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic              clk,
   input  logic              rst,
   // instruction fetch requester
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [31:0]       if_rdata,
   output logic              if_valid,
   // data requester
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [1:0]        dm_wsize,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [31:0]       dm_wdata,
   output logic [31:0]       dm_rdata,
   output logic              dm_valid,
   // pipeline stalls
   output logic              stall_if,
   output logic              stall_dm,
   // shared memory port
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [1:0]        mem_wsize,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack,
   // sticky timeout flag
   output logic              err
);

   localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam int BW = (TIMEOUT < 2)    ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
   localparam logic [BW-1:0] BUSY_LIM   = BW'(TIMEOUT);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      BUSY_IF = 3'd1,
      BUSY_DM = 3'd2,
      DONE_IF = 3'd3,
      DONE_DM = 3'd4
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [SW-1:0]   starve_cnt;
   logic [BW-1:0]   busy_cnt;
   logic            timeout_hit;

   // The access is abandoned once the current BUSY cycle is the TIMEOUT-th one
   assign timeout_hit = (busy_cnt == BUSY_LIM) && !mem_ack;

   // Stalls hold the requesting stage until its completion pulse
   assign stall_if = if_req & ~if_valid;
   assign stall_dm = dm_req & ~dm_valid;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Arbitration, next-state and memory-port drive
   always_comb begin
      state_nx  = state;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wsize = '0;
      if_valid  = 1'b0;
      dm_valid  = 1'b0;
      case (state)
         IDLE: begin
            if (dm_req && (!if_req || (starve_cnt < STARVE_LIM))) state_nx = BUSY_DM;
            else if (if_req)                                       state_nx = BUSY_IF;
         end
         BUSY_IF: begin
            mem_req  = 1'b1;
            mem_addr = if_addr;
            if (mem_ack || timeout_hit) state_nx = DONE_IF;
         end
         BUSY_DM: begin
            mem_req   = 1'b1;
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
            mem_wsize = dm_wsize;
            if (mem_ack || timeout_hit) state_nx = DONE_DM;
         end
         DONE_IF: begin
            if_valid = 1'b1;
            state_nx = IDLE;
         end
         DONE_DM: begin
            dm_valid = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Fairness counter, BUSY-cycle counter, read-data capture and error flag
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
         busy_cnt   <= '0;
         err        <= 1'b0;
         if_rdata   <= '0;
         dm_rdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               // BUSY cycles are numbered from 1, so preload on a grant
               busy_cnt <= (state_nx == IDLE) ? '0 : BW'(1);
               if (!if_req || (state_nx == BUSY_IF))
                  starve_cnt <= '0;
               else if ((state_nx == BUSY_DM) && (starve_cnt != STARVE_LIM))
                  starve_cnt <= starve_cnt + 1'b1;
            end
            BUSY_IF: begin
               if (mem_ack) begin
                  if_rdata <= mem_rdata;
                  busy_cnt <= '0;
               end else if (timeout_hit) begin
                  if_rdata <= '0;
                  err      <= 1'b1;
                  busy_cnt <= '0;
               end else begin
                  busy_cnt <= busy_cnt + 1'b1;
               end
            end
            BUSY_DM: begin
               if (mem_ack) begin
                  // a store returns no data; the last load value is kept
                  if (!dm_we) dm_rdata <= mem_rdata;
                  busy_cnt <= '0;
               end else if (timeout_hit) begin
                  dm_rdata <= '0;
                  err      <= 1'b1;
                  busy_cnt <= '0;
               end else begin
                  busy_cnt <= busy_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, byte-address width of both requesters and the memory port.
REQ-002 Parameter STARVE_MAX, default 4, consecutive DM grants allowed while IF waits.
REQ-003 Parameter TIMEOUT, default 255, BUSY cycles without mem_ack before abort.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 if_req  in  1  fetch request, held until if_valid.
REQ-007 if_addr  in  ADDR_W  fetch byte address, stable while if_req.
REQ-008 if_rdata  out  32  fetched word, valid with if_valid.
REQ-009 if_valid  out  1  one-cycle completion pulse for fetch.
REQ-010 dm_req  in  1  data request, held until dm_valid.
REQ-011 dm_we  in  1  1 = store, 0 = load.
REQ-012 dm_wsize  in  2  store size code, forwarded unchanged.
REQ-013 dm_addr  in  ADDR_W  data byte address.
REQ-014 dm_wdata  in  32  store data.
REQ-015 dm_rdata  out  32  load data, valid with dm_valid.
REQ-016 dm_valid  out  1  one-cycle completion pulse for data access.
REQ-017 stall_if / stall_dm  out  1 each  pipeline stall requests.
REQ-018 mem_req, mem_we  out  1 each  shared-port request and write enable.
REQ-019 mem_addr  out  ADDR_W; mem_wdata  out  32; mem_wsize  out  2.
REQ-020 mem_rdata  in  32; mem_ack  in  1  one-cycle completion from memory; may arrive in the first mem_req cycle.
REQ-021 err  out  1  sticky timeout flag.

Function
REQ-022 States: IDLE, BUSY_IF, BUSY_DM, DONE_IF, DONE_DM.
REQ-023 IDLE: dm_req and (if_req low or starve_cnt < STARVE_MAX) -> BUSY_DM; else if_req -> BUSY_IF; else stay.
REQ-024 In IDLE with starve_cnt == STARVE_MAX and both requests high, IF SHALL win.
REQ-025 starve_cnt increments (saturating at STARVE_MAX) on each DM grant while if_req is high; clears on IF grant or whenever if_req is low in IDLE.
REQ-026 BUSY_x: mem_req = 1; mem_addr/mem_we/mem_wdata/mem_wsize driven from requester x (mem_we = 0, mem_wsize = 0, mem_wdata = 0 for IF); held stable until mem_ack.
REQ-027 BUSY_x with mem_ack: capture mem_rdata into x_rdata (DM store: dm_rdata holds previous value) -> DONE_x.
REQ-028 DONE_x: x_valid = 1 for exactly that cycle; mem_req = 0; requests not sampled -> IDLE.
REQ-029 Minimum latency: req sampled at edge k, mem_req during cycle k+1, ack same cycle, x_valid during cycle k+2, next arbitration at edge k+3.
REQ-030 Outside BUSY: mem_req = 0, mem_we = 0; mem_addr/mem_wdata/mem_wsize = 0.
REQ-031 Timeout: busy_cnt counts BUSY cycles from 1; at busy_cnt == TIMEOUT without mem_ack -> err = 1 (sticky), x_rdata = 0, -> DONE_x.
REQ-032 mem_ack outside BUSY SHALL be ignored.
REQ-033 stall_if = if_req & ~if_valid; stall_dm = dm_req & ~dm_valid (combinational).
REQ-034 A request dropped mid-BUSY SHALL NOT abort the memory access; its valid pulse still occurs.

Reset
REQ-035 rst high at posedge -> state IDLE, starve_cnt = 0, busy_cnt = 0, err = 0, if_rdata = 0, dm_rdata = 0, if_valid = 0, dm_valid = 0, mem_req = 0, regardless of state (aborts in-flight access with no valid pulse).

Verification
REQ-036 if_req, addr 0x010, mem_ack in first mem_req cycle, mem_rdata 0x20080005 -> if_valid in cycle 2, if_rdata = 0x20080005.
REQ-037 if_req and dm_req (load 0x004) both held, ack 1 cycle -> grant order DM,DM,DM,DM,IF,DM...; IF waits at most 4 DM grants.
REQ-038 dm store, addr 0x3FC, wdata 0xDEADBEEF, wsize 2 -> mem_we = 1, mem_addr = 0x3FC, mem_wdata = 0xDEADBEEF, mem_wsize = 2; dm_valid 1 cycle after ack, dm_rdata unchanged.
REQ-039 mem_ack never asserted, TIMEOUT = 255 -> after 255 BUSY cycles err = 1, dm_valid pulses with dm_rdata = 0; err stays 1 until rst.
REQ-040 rst asserted during BUSY_DM -> next cycle mem_req = 0, no dm_valid, err = 0; a late mem_ack is ignored.
